// File: rtl/lvds_tx_pkg.sv
// lvds_tx shared definitions
// sync patterns, frame geometry, FSM encodings, frame builders
package lvds_tx_pkg;

  localparam logic [1:0] SYNC_I_DEF = 2'b10;
  localparam logic [1:0] SYNC_Q_DEF = 2'b01;

  localparam int         FRAME_BITS   = 32;
  localparam logic [3:0] PHASE_DECIDE = 4'd14;
  localparam logic [3:0] PHASE_LAST   = 4'd15;

  localparam logic [31:0] SYNC_MASK = 32'hC000_C000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_TX   = 2'd2
  } state_t;

  // what the next frame boundary loads
  typedef enum logic [1:0] {
    NXT_FIFO,
    NXT_TEST,
    NXT_ZERO,
    NXT_STOP
  } nxt_t;

  function automatic logic [31:0] zero_frame(
    input logic [1:0] si,
    input logic [1:0] sq
  );
    return {si, 14'b0, sq, 14'b0};
  endfunction

  function automatic logic [31:0] force_sync(
    input logic [31:0] w,
    input logic [1:0]  si,
    input logic [1:0]  sq
  );
    return (w & ~SYNC_MASK) | zero_frame(si, sq);
  endfunction

  function automatic logic [31:0] ramp_frame(
    input logic [12:0] r,
    input logic [1:0]  si,
    input logic [1:0]  sq
  );
    return {si, r, 1'b0, sq, ~r, 1'b0};
  endfunction

endpackage

// File: rtl/lvds_tx_if.sv
// lvds_tx FIFO read port
// master = serializer pulling words, slave = TX FIFO
interface lvds_tx_if;
  logic        i_fifo_empty;
  logic [31:0] i_fifo_data;
  logic        o_fifo_pull;

  modport master (
    input  i_fifo_empty,
    input  i_fifo_data,
    output o_fifo_pull
  );

  modport slave (
    output i_fifo_empty,
    output i_fifo_data,
    input  o_fifo_pull
  );
endinterface

// File: rtl/lvds_tx.sv
// lvds_tx: 32-bit I/Q frame serializer, 2 bits per clock
// frame-atomic, forced sync bits, zero frame on underrun
module lvds_tx
  import lvds_tx_pkg::*;
#(
  parameter logic [1:0] SYNC_I     = SYNC_I_DEF,
  parameter logic [1:0] SYNC_Q     = SYNC_Q_DEF,
  parameter int         UNDR_CNT_W = 8
) (
  input  logic                  i_ddr_clk,
  input  logic                  i_rst,
  input  logic                  i_tx_enable,
  input  logic                  i_test_mode,
  lvds_tx_if.master             fifo,
  output logic [1:0]            o_ddr_data,
  output logic                  o_tx_active,
  output logic                  o_underrun,
  output logic [UNDR_CNT_W-1:0] o_underrun_count,
  output logic [1:0]            o_debug_state
);

  state_t                state;
  nxt_t                  nxt;
  logic [3:0]            phase;
  logic [FRAME_BITS-1:0] sr;
  logic [12:0]           ramp;
  logic                  idle_go;
  logic                  decide;
  logic                  pull;
  logic [FRAME_BITS-1:0] load_word;

  // start condition and FIFO read strobe (data arrives next cycle)
  always_comb begin
    idle_go = i_tx_enable & (i_test_mode | ~fifo.i_fifo_empty);
    decide  = (state == ST_TX) & (phase == PHASE_DECIDE);
    pull    = 1'b0;
    if (state == ST_IDLE)
      pull = idle_go & ~i_test_mode;
    else if (decide)
      pull = i_tx_enable & ~i_test_mode & ~fifo.i_fifo_empty;
    pull = pull & ~i_rst;
  end

  // word loaded into the shift register at a frame boundary
  always_comb begin
    load_word = force_sync(fifo.i_fifo_data, SYNC_I, SYNC_Q);
    unique case (1'b1)
      nxt == NXT_TEST: load_word = ramp_frame(ramp, SYNC_I, SYNC_Q);
      nxt == NXT_ZERO: load_word = zero_frame(SYNC_I, SYNC_Q);
      default: ;
    endcase
  end

  // FSM, phase counter, shift register and status flags
  always_ff @(posedge i_ddr_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      nxt              <= NXT_STOP;
      phase            <= 4'd0;
      sr               <= '0;
      ramp             <= 13'd0;
      o_tx_active      <= 1'b0;
      o_underrun       <= 1'b0;
      o_underrun_count <= '0;
    end else begin
      o_underrun <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (idle_go) begin
            state <= ST_PRE;
            nxt   <= i_test_mode ? NXT_TEST : NXT_FIFO;
            ramp  <= 13'd0;
          end
        end
        ST_PRE: begin
          state       <= ST_TX;
          phase       <= 4'd0;
          sr          <= load_word;
          o_tx_active <= 1'b1;
          if (nxt == NXT_TEST)
            ramp <= ramp + 13'd1;
        end
        ST_TX: begin
          phase <= phase + 4'd1;
          sr    <= {sr[FRAME_BITS-3:0], 2'b00};
          if (decide) begin
            if (!i_tx_enable)
              nxt <= NXT_STOP;
            else if (i_test_mode)
              nxt <= NXT_TEST;
            else if (fifo.i_fifo_empty)
              nxt <= NXT_ZERO;
            else
              nxt <= NXT_FIFO;
          end
          if (phase == PHASE_LAST) begin
            if (nxt == NXT_STOP) begin
              state       <= ST_IDLE;
              sr          <= '0;
              o_tx_active <= 1'b0;
            end else begin
              sr <= load_word;
              if (nxt == NXT_TEST)
                ramp <= ramp + 13'd1;
              if (nxt == NXT_ZERO) begin
                o_underrun <= 1'b1;
                if (~&o_underrun_count)
                  o_underrun_count <= o_underrun_count
                                    + UNDR_CNT_W'(1);
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fifo.o_fifo_pull = pull;
  assign o_ddr_data       = sr[FRAME_BITS-1:FRAME_BITS-2];
  assign o_debug_state    = state;

endmodule
